// File: rtl/logicnet_stream_ctrl_if.sv
// rtl/logicnet_stream_ctrl_if.sv - sample stream, net boundary and result stream bundle
interface logicnet_stream_ctrl_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 2
);
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic [IN_W-1:0]  net_in;
    logic [OUT_W-1:0] net_out;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, net_out, m_ready,
        output s_ready, net_in, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, net_out, m_ready,
        input  s_ready, net_in, m_valid, m_data
    );
endinterface

// File: rtl/logicnet_stream_ctrl.sv
// rtl/logicnet_stream_ctrl.sv - credit-based stream controller around a free-running pipelined classifier
module logicnet_stream_ctrl #(
    parameter int IN_W        = 64,
    parameter int OUT_W       = 2,
    parameter int PIPE_STAGES = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    logicnet_stream_ctrl_if.slave  bus,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       in_count_o,
    output logic [CNT_W-1:0]       out_count_o
);
    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam int          FCNT_W  = PTR_W + 1;
    localparam int          INF_W   = $clog2(PIPE_STAGES + 2);
    localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

    logic [IN_W-1:0]    net_in_q, net_in_d;
    logic [PIPE_STAGES:0] vld_q, vld_d;
    logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [INF_W-1:0]   inflight;
    logic               s_ready, m_valid, acc, push, pop;

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= PIPE_STAGES; k++) begin
            inflight = inflight + INF_W'(vld_q[k]);
        end
    end

    // Every token in the net already owns a FIFO slot, so the net never stalls.
    assign s_ready = (32'(fcnt_q) + 32'(inflight)) < DEPTH_U;
    assign m_valid = (fcnt_q != '0);
    assign acc     = bus.s_valid & s_ready;
    assign push    = vld_q[PIPE_STAGES];
    assign pop     = m_valid & bus.m_ready;

    always_comb begin
        net_in_d  = acc ? bus.s_data : net_in_q;
        vld_d     = '0;
        vld_d[0]  = acc;
        for (int k = 1; k <= PIPE_STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        wr_d      = wr_q + PTR_W'(push);
        rd_d      = rd_q + PTR_W'(pop);
        fcnt_d    = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
        in_cnt_d  = in_cnt_q + CNT_W'(acc);
        out_cnt_d = out_cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            net_in_q  <= '0;
            vld_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fcnt_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            net_in_q  <= net_in_d;
            vld_q     <= vld_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fcnt_q    <= fcnt_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            if (push) begin
                mem_q[wr_q] <= bus.net_out;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (fcnt_q < FCNT_W'(FIFO_DEPTH)));

    assign bus.s_ready  = s_ready;
    assign bus.net_in   = net_in_q;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = mem_q[rd_q];
    assign busy_o       = (|vld_q) | m_valid;
    assign in_count_o   = in_cnt_q;
    assign out_count_o  = out_cnt_q;
endmodule

// File: tb/tb_logicnet_stream_ctrl.sv
// tb/tb_logicnet_stream_ctrl.sv - directed bench for logicnet_stream_ctrl with a 3-stage net model
module tb_logicnet_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logicnet_stream_ctrl_if #(.IN_W(64), .OUT_W(2)) bus4 ();
    logicnet_stream_ctrl_if #(.IN_W(64), .OUT_W(2)) bus8 ();

    logic        busy4, busy8;
    logic [31:0] inc4, outc4, inc8, outc8;

    logicnet_stream_ctrl #(.IN_W(64), .OUT_W(2), .PIPE_STAGES(3), .FIFO_DEPTH(4), .CNT_W(32)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .bus(bus4.slave),
        .busy_o(busy4), .in_count_o(inc4), .out_count_o(outc4)
    );
    logicnet_stream_ctrl #(.IN_W(64), .OUT_W(2), .PIPE_STAGES(3), .FIFO_DEPTH(8), .CNT_W(32)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .bus(bus8.slave),
        .busy_o(busy8), .in_count_o(inc8), .out_count_o(outc8)
    );

    function automatic logic [1:0] net_f(input logic [63:0] d);
        return d[1:0] ^ d[3:2];
    endfunction

    // Classifier model: combinational layer followed by three pipeline registers.
    logic [1:0] n4_q [3];
    logic [1:0] n8_q [3];
    always_ff @(posedge clk) begin
        n4_q[0] <= net_f(bus4.net_in);
        n4_q[1] <= n4_q[0];
        n4_q[2] <= n4_q[1];
        n8_q[0] <= net_f(bus8.net_in);
        n8_q[1] <= n8_q[0];
        n8_q[2] <= n8_q[1];
    end
    assign bus4.net_out = n4_q[2];
    assign bus8.net_out = n8_q[2];

    int errors = 0;
    int checks = 0;
    logic [1:0] q4[$];
    logic [1:0] q8[$];
    logic last_acc;
    int pops4 = 0;
    int pops8 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the selected instance, scoreboard any pop, record any accept.
    task automatic step(input bit sel, input logic v, input logic [63:0] d, input logic mr);
        logic rdy, mv;
        logic [1:0] md, e;
        if (!sel) begin
            bus4.s_valid = v; bus4.s_data = d; bus4.m_ready = mr;
            #0;
            rdy = bus4.s_ready; mv = bus4.m_valid; md = bus4.m_data;
        end else begin
            bus8.s_valid = v; bus8.s_data = d; bus8.m_ready = mr;
            #0;
            rdy = bus8.s_ready; mv = bus8.m_valid; md = bus8.m_data;
        end
        last_acc = v && rdy;
        if (mv && mr) begin
            if (!sel) begin
                pops4++;
                e = (q4.size() != 0) ? q4.pop_front() : 2'bxx;
                chk("order4", {62'd0, md}, {62'd0, e});
            end else begin
                pops8++;
                e = (q8.size() != 0) ? q8.pop_front() : 2'bxx;
                chk("order8", {62'd0, md}, {62'd0, e});
            end
        end
        if (last_acc) begin
            if (!sel) q4.push_back(net_f(d));
            else      q8.push_back(net_f(d));
        end
        tick();
    endtask

    logic [63:0] tv [10];
    int accs, drops, sent, guard, exp_in;

    initial begin
        tv = '{64'h1, 64'h2, 64'h3, 64'h5, 64'hF, 64'hA, 64'h7, 64'h9, 64'hE, 64'h4};
        bus4.s_valid = 1'b1; bus4.s_data = 64'hFFFF; bus4.m_ready = 1'b0;
        bus8.s_valid = 1'b1; bus8.s_data = 64'hFFFF; bus8.m_ready = 1'b0;
        rst = 1'b1;

        // Reset with s_valid held high
        tick(); tick();
        chk("rst_s_ready", bus4.s_ready, 1);
        chk("rst_m_valid", bus4.m_valid, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_in_count", inc4, 0);
        chk("rst_out_count", outc4, 0);
        chk("rst_m_data", bus4.m_data, 0);
        chk("rst_net_in", bus4.net_in, 0);
        chk("rst_in_count8", inc8, 0);
        rst = 1'b0;
        bus4.s_valid = 1'b0; bus8.s_valid = 1'b0;
        tick(); tick(); tick();

        // Latency: accept at edge 0, result visible after edge 4
        step(0, 1, 64'h3, 0);
        chk("lat_in_count", inc4, 1);
        chk("lat_busy", busy4, 1);
        chk("lat_mv_e0", bus4.m_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 64'h0, 0);
            chk("lat_mv_early", bus4.m_valid, 0);
        end
        step(0, 0, 64'h0, 0);
        chk("lat_mv_e4", bus4.m_valid, 1);
        chk("lat_m_data", bus4.m_data, 2'b11);
        step(0, 0, 64'h0, 1);
        chk("lat_out_count", outc4, 1);
        chk("lat_busy_after", busy4, 0);
        chk("lat_mv_after", bus4.m_valid, 0);

        // Backpressure: exactly FIFO_DEPTH accepts while m_ready=0
        accs = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, tv[i], 0);
            accs += int'(last_acc);
        end
        chk("bp_accepts", accs, 4);
        chk("bp_s_ready", bus4.s_ready, 0);
        chk("bp_m_valid", bus4.m_valid, 1);
        chk("bp_in_count", inc4, 5);
        chk("bp_head", bus4.m_data, 2'b01);
        for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 1);
        chk("bp_pops", pops4, 5);
        chk("bp_drained", bus4.m_valid, 0);
        chk("bp_out_count", outc4, 5);
        chk("bp_resume", bus4.s_ready, 1);

        // Full FIFO then concurrent push/pop
        for (int i = 0; i < 8; i++) step(0, 1, 64'(i + 20), 0);
        chk("full_in_count", inc4, 9);
        chk("full_s_ready", bus4.s_ready, 0);
        exp_in = 9;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 64'(i * 3 + 1), 1);
            exp_in += int'(last_acc);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 64'h0, 1);
        chk("pp_in_count", inc4, 64'(exp_in));
        chk("pp_out_count", outc4, 64'(exp_in));
        chk("pp_queue_empty", q4.size(), 0);
        chk("pp_busy", busy4, 0);

        // Streaming on the deeper instance
        sent = 0; drops = 0; guard = 0;
        while (sent < 100 && guard < 300) begin
            step(1, 1, {32'(sent * 7), 32'(sent)}, 1);
            if (last_acc) sent++;
            else          drops++;
            guard++;
        end
        for (int i = 0; i < 12; i++) step(1, 0, 64'h0, 1);
        chk("st_drops", drops, 0);
        chk("st_sent", sent, 100);
        chk("st_in_count", inc8, 100);
        chk("st_out_count", outc8, 100);
        chk("st_pops", pops8, 100);
        chk("st_busy", busy8, 0);

        // Reset with 2 buffered and 3 in flight
        step(1, 1, 64'h1, 0);
        step(1, 1, 64'h2, 0);
        step(1, 0, 64'h0, 0);
        step(1, 0, 64'h0, 0);
        step(1, 1, 64'h3, 0);
        step(1, 1, 64'h5, 0);
        step(1, 1, 64'h1, 0);
        chk("mr_pre_mv", bus8.m_valid, 1);
        chk("mr_pre_in", inc8, 105);
        bus8.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q8.delete();
        chk("mr_m_valid", bus8.m_valid, 0);
        chk("mr_busy", busy8, 0);
        chk("mr_s_ready", bus8.s_ready, 1);
        chk("mr_in_count", inc8, 0);
        chk("mr_out_count", outc8, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 64'h0, 1);
            chk("mr_no_stale", bus8.m_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
